ddr3_dfi_sequencer: RTL and testbench
=====================================

// Module: ddr3_dfi_sequencer
// PURPOSE
//  DFI-side initiator for the DDR3 PHY. Takes one simple controller command per cycle (valid/ready),
//  enforces DDR3 command-to-command timing, and drives the PHY's DFI command, write and read-enable ports.
//  Schedules 4-cycle BL8 write/read bursts; write data is pulled from an upstream stream and
//  returned read data is forwarded with a last-beat flag. All timing is in 'clock' cycles (= DDR CK).
// PARAMETERS
//  DDR3_WIDTH 16   DQ width; per-cycle data bus is 2*DDR3_WIDTH bits (DSB=2*W-1), mask 2*W/8 bits (SSB)
//  ADDR_BITS  14   DDR3 address width (ASB=ADDR_BITS-1)
//  WR_LAT     4    cycles from WRITE issue to first dfi_wren_o beat
//  RD_LAT     5    cycles from READ issue to first dfi_rden_o beat
//  TRCD 6, TRP 6, TRFC 44, TWR 6, TWTR 4, TRTW 6   minimum gaps in cycles (see BEHAVIOUR)
// PORTS
//  clock        in   1    controller clock
//  reset        in   1    synchronous, active-high
//  ctl_cke_i    in   1    requested CKE (registered to dfi_cke_o)
//  ctl_rst_ni   in   1    requested DDR3 RESET# (registered to dfi_rst_no)
//  cmd_valid_i  in   1    command request
//  cmd_ready_o  out  1    command accepted this cycle when valid&ready
//  cmd_code_i   in   3    0 NOP,1 ACT,2 READ,3 WRITE,4 PRE,5 PREA,6 REF,7 MRS
//  cmd_bank_i   in   3    bank / MR select
//  cmd_addr_i   in   ASB+1 row, column or MR value
//  wr_valid_i   in   1    write beat available
//  wr_ready_o   out  1    write beat consumed (== dfi_wren_o next cycle)
//  wr_mask_i    in   SSB+1 byte masks, 1 = masked
//  wr_data_i    in   DSB+1 {hi,lo} DDR pair
//  rd_valid_o   out  1    read beat valid
//  rd_last_o    out  1    4th beat of a burst
//  rd_data_o    out  DSB+1 read beat
//  wr_underrun_o out 1    sticky: a scheduled beat found wr_valid_i low
//  dfi_cke_o, dfi_rst_no, dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no, dfi_odt_o  out 1 each
//  dfi_bank_o out 3; dfi_addr_o out ASB+1; dfi_wren_o out 1; dfi_mask_o out SSB+1; dfi_data_o out DSB+1
//  dfi_rden_o out 1; dfi_valid_i in 1; dfi_data_i in DSB+1   PHY read return
// BEHAVIOUR
//  - Reset: cke 0, rst_n 0, cs_n/ras_n/cas_n/we_n 1, odt 0, bank/addr 0, wren/rden 0, mask/data 0,
//    rd_valid/rd_last 0, wr_underrun 0, all gap counters 0, burst pipelines and beat counter flushed.
//    Reset mid-burst abandons the burst; no further wren/rden/rd_valid until new commands.
//  - All DFI outputs registered; accepted command appears on DFI the cycle after valid&ready.
//    Cycles with no accepted command drive deselect (cs_n=1, ras/cas/we_n=1, bank/addr hold).
//  - Encodings {ras_n,cas_n,we_n}: ACT 011, READ 101, WRITE 100, PRE/PREA 010 (PREA sets A10=1,
//    PRE forces A10=0), REF 001, MRS 000, NOP 111 with cs_n=0. READ/WRITE force A10=0 (no auto-PRE).
//  - cmd_ready_o is combinational on cmd_code_i and down-counters (each loaded at issue, decrements to 0):
//    ACT needs pre_cnt=0 & ref_cnt=0; READ needs rcd_cnt=0 & wtr_cnt=0 & bst_cnt=0;
//    WRITE needs rcd_cnt=0 & rtw_cnt=0 & bst_cnt=0; PRE/PREA need wr_cnt=0 & bst_cnt=0;
//    REF/MRS need every counter 0; NOP always ready.
//  - Loads: ACT->rcd=TRCD-1; PRE/PREA->pre=TRP-1; REF->ref=TRFC-1; READ->bst=3, rtw=TRTW-1;
//    WRITE->bst=3, wtr=WR_LAT+4+TWTR-1, wr=WR_LAT+4+TWR-1. Counters saturate at 0.
//  - Write burst: WRITE issued (DFI) at cycle t -> dfi_wren_o=1 for t+WR_LAT..t+WR_LAT+3.
//    wr_ready_o=1 the cycle before each wren beat; beat registered to dfi_data_o/dfi_mask_o.
//    If wr_valid_i=0 when wr_ready_o=1: dfi_mask_o=all-ones, data 0, wr_underrun_o set (cleared only by reset).
//    dfi_odt_o=1 from t+WR_LAT-1 through t+WR_LAT+4 inclusive; overlapping windows merge.
//  - Read burst: READ issued at t -> dfi_rden_o=1 for t+RD_LAT..t+RD_LAT+3.
//    dfi_valid_i/dfi_data_i registered to rd_valid_o/rd_data_o (1-cycle latency, no backpressure);
//    2-bit beat counter increments per valid beat, rd_last_o on count 3, wraps to 0.
//  - Back-to-back same-type bursts at 4-cycle spacing produce continuous wren/rden (no gap).
//  - ctl_cke_i/ctl_rst_ni are registered straight through, independent of command traffic.
// TESTING
//  - Reset then idle 10 cycles -> cs_n=1, cke=0, rst_n=0, wren/rden/odt=0, cmd_ready_o=1 for NOP.
//  - ACT@c0 then READ held valid -> READ accepted at c0+TRCD (c6), READ on DFI at c7, rden c12..c15.
//  - WRITE with 4 beats 0xA..D ready -> wren at t+4..t+7 carrying A,B,C,D; odt t+3..t+8; PRE blocked until wr=0.
//  - WRITE with wr_valid_i low on beat 2 -> that beat mask=all-ones, wr_underrun_o=1 and stays 1.
//  - READ then WRITE requested back-to-back -> WRITE accepted exactly TRTW cycles after READ; WRITE then READ -> gap WR_LAT+4+TWTR.
//  - REF mid-TRFC reset: assert reset at REF+10 -> counters clear, ACT accepted first cycle after reset release.

Source files
------------

// File: rtl/ddr3_dfi_sequencer.sv
// rtl/ddr3_dfi_sequencer.sv - DDR3 DFI command sequencer with timing gates and BL8 burst scheduling
module ddr3_dfi_sequencer #(
  parameter int DDR3_WIDTH = 16,
  parameter int ADDR_BITS  = 14,
  parameter int WR_LAT     = 4,   // must be >= 2 (ODT opens one cycle before the first ready)
  parameter int RD_LAT     = 5,   // must be >= 1
  parameter int TRCD       = 6,
  parameter int TRP        = 6,
  parameter int TRFC       = 44,
  parameter int TWR        = 6,
  parameter int TWTR       = 4,
  parameter int TRTW       = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ctl_cke_i,
  input  logic                      ctl_rst_ni,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [2:0]                cmd_code_i,
  input  logic [2:0]                cmd_bank_i,
  input  logic [ADDR_BITS-1:0]      cmd_addr_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [2*DDR3_WIDTH/8-1:0] wr_mask_i,
  input  logic [2*DDR3_WIDTH-1:0]   wr_data_i,
  output logic                      rd_valid_o,
  output logic                      rd_last_o,
  output logic [2*DDR3_WIDTH-1:0]   rd_data_o,
  output logic                      wr_underrun_o,
  output logic                      dfi_cke_o,
  output logic                      dfi_rst_no,
  output logic                      dfi_cs_no,
  output logic                      dfi_ras_no,
  output logic                      dfi_cas_no,
  output logic                      dfi_we_no,
  output logic                      dfi_odt_o,
  output logic [2:0]                dfi_bank_o,
  output logic [ADDR_BITS-1:0]      dfi_addr_o,
  output logic                      dfi_wren_o,
  output logic [2*DDR3_WIDTH/8-1:0] dfi_mask_o,
  output logic [2*DDR3_WIDTH-1:0]   dfi_data_o,
  output logic                      dfi_rden_o,
  input  logic                      dfi_valid_i,
  input  logic [2*DDR3_WIDTH-1:0]   dfi_data_i
);

  localparam int DW  = 2 * DDR3_WIDTH;
  localparam int MW  = DW / 8;
  localparam int CW  = 8;
  localparam int A10 = 10;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_ACT   = 3'd1;
  localparam logic [2:0] CMD_READ  = 3'd2;
  localparam logic [2:0] CMD_WRITE = 3'd3;
  localparam logic [2:0] CMD_PRE   = 3'd4;
  localparam logic [2:0] CMD_PREA  = 3'd5;
  localparam logic [2:0] CMD_REF   = 3'd6;
  localparam logic [2:0] CMD_MRS   = 3'd7;

  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] LD_RCD = CW'(TRCD - 1);
  localparam logic [CW-1:0] LD_PRE = CW'(TRP - 1);
  localparam logic [CW-1:0] LD_REF = CW'(TRFC - 1);
  localparam logic [CW-1:0] LD_BST = CW'(3);
  localparam logic [CW-1:0] LD_RTW = CW'(TRTW - 1);
  localparam logic [CW-1:0] LD_WTR = CW'(WR_LAT + 4 + TWTR - 1);
  localparam logic [CW-1:0] LD_WR  = CW'(WR_LAT + 4 + TWR - 1);

  logic [CW-1:0] rcd_cnt, pre_cnt, ref_cnt, bst_cnt, rtw_cnt, wtr_cnt, wr_cnt;
  logic          cnt_all_zero;
  logic [2:0]    cmd_enc;
  logic [ADDR_BITS-1:0] addr_next;
  logic          issue, iss_act, iss_read, iss_write, iss_pre, iss_ref;

  // wr_hist[i] / rd_hist[i] set means a WRITE / READ was on DFI i cycles ago
  logic [WR_LAT+3:0] wr_hist;
  logic [RD_LAT+2:0] rd_hist;
  logic              odt_next, rden_next;
  logic [1:0]        rd_beat;

  function automatic logic [CW-1:0] step_cnt(input logic [CW-1:0] cnt,
                                             input logic load,
                                             input logic [CW-1:0] val);
    if (load)
      return val;
    else if (cnt != '0)
      return cnt - ONE;
    else
      return '0;
  endfunction

  assign cnt_all_zero = ~|{rcd_cnt, pre_cnt, ref_cnt, bst_cnt, rtw_cnt, wtr_cnt, wr_cnt};

  // Gate the request on the timing counters and build the DFI encoding / address for it
  always_comb begin
    cmd_ready_o = 1'b1;
    cmd_enc     = 3'b111;
    addr_next   = cmd_addr_i;
    case (cmd_code_i)
      CMD_NOP: begin
        cmd_ready_o = 1'b1;
        cmd_enc     = 3'b111;
      end
      CMD_ACT: begin
        cmd_ready_o = (pre_cnt == '0) && (ref_cnt == '0);
        cmd_enc     = 3'b011;
      end
      CMD_READ: begin
        cmd_ready_o    = (rcd_cnt == '0) && (wtr_cnt == '0) && (bst_cnt == '0);
        cmd_enc        = 3'b101;
        addr_next[A10] = 1'b0;
      end
      CMD_WRITE: begin
        cmd_ready_o    = (rcd_cnt == '0) && (rtw_cnt == '0) && (bst_cnt == '0);
        cmd_enc        = 3'b100;
        addr_next[A10] = 1'b0;
      end
      CMD_PRE: begin
        cmd_ready_o    = (wr_cnt == '0) && (bst_cnt == '0);
        cmd_enc        = 3'b010;
        addr_next[A10] = 1'b0;
      end
      CMD_PREA: begin
        cmd_ready_o    = (wr_cnt == '0) && (bst_cnt == '0);
        cmd_enc        = 3'b010;
        addr_next[A10] = 1'b1;
      end
      CMD_REF: begin
        cmd_ready_o = cnt_all_zero;
        cmd_enc     = 3'b001;
      end
      CMD_MRS: begin
        cmd_ready_o = cnt_all_zero;
        cmd_enc     = 3'b000;
      end
      default: begin
        cmd_ready_o = 1'b1;
        cmd_enc     = 3'b111;
      end
    endcase
  end

  assign issue     = cmd_valid_i & cmd_ready_o;
  assign iss_act   = issue && (cmd_code_i == CMD_ACT);
  assign iss_read  = issue && (cmd_code_i == CMD_READ);
  assign iss_write = issue && (cmd_code_i == CMD_WRITE);
  assign iss_pre   = issue && ((cmd_code_i == CMD_PRE) || (cmd_code_i == CMD_PREA));
  assign iss_ref   = issue && (cmd_code_i == CMD_REF);

  // Burst windows decoded from the issue history
  assign wr_ready_o = |wr_hist[WR_LAT+2:WR_LAT-1];
  assign odt_next   = |wr_hist[WR_LAT+3:WR_LAT-2];
  assign rden_next  = |rd_hist[RD_LAT+2:RD_LAT-1];

  // Timing down-counters: load on issue, otherwise count down and hold at zero
  always_ff @(posedge clock) begin
    if (reset) begin
      rcd_cnt <= '0;
      pre_cnt <= '0;
      ref_cnt <= '0;
      bst_cnt <= '0;
      rtw_cnt <= '0;
      wtr_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      rcd_cnt <= step_cnt(rcd_cnt, iss_act, LD_RCD);
      pre_cnt <= step_cnt(pre_cnt, iss_pre, LD_PRE);
      ref_cnt <= step_cnt(ref_cnt, iss_ref, LD_REF);
      bst_cnt <= step_cnt(bst_cnt, iss_read | iss_write, LD_BST);
      rtw_cnt <= step_cnt(rtw_cnt, iss_read, LD_RTW);
      wtr_cnt <= step_cnt(wtr_cnt, iss_write, LD_WTR);
      wr_cnt  <= step_cnt(wr_cnt, iss_write, LD_WR);
    end
  end

  // DFI command bus: accepted command for one cycle, deselect otherwise; CKE/RESET# pass through
  always_ff @(posedge clock) begin
    if (reset) begin
      dfi_cke_o  <= 1'b0;
      dfi_rst_no <= 1'b0;
      dfi_cs_no  <= 1'b1;
      dfi_ras_no <= 1'b1;
      dfi_cas_no <= 1'b1;
      dfi_we_no  <= 1'b1;
      dfi_bank_o <= '0;
      dfi_addr_o <= '0;
    end else begin
      dfi_cke_o  <= ctl_cke_i;
      dfi_rst_no <= ctl_rst_ni;
      if (issue) begin
        dfi_cs_no                            <= 1'b0;
        {dfi_ras_no, dfi_cas_no, dfi_we_no}  <= cmd_enc;
        dfi_bank_o                           <= cmd_bank_i;
        dfi_addr_o                           <= addr_next;
      end else begin
        dfi_cs_no                            <= 1'b1;
        {dfi_ras_no, dfi_cas_no, dfi_we_no}  <= 3'b111;
      end
    end
  end

  // Write path: issue history, ODT window and beat capture with underrun masking
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_hist       <= '0;
      dfi_wren_o    <= 1'b0;
      dfi_odt_o     <= 1'b0;
      dfi_mask_o    <= '0;
      dfi_data_o    <= '0;
      wr_underrun_o <= 1'b0;
    end else begin
      wr_hist    <= {wr_hist[WR_LAT+2:0], iss_write};
      dfi_wren_o <= wr_ready_o;
      dfi_odt_o  <= odt_next;
      if (wr_ready_o && wr_valid_i) begin
        dfi_mask_o <= wr_mask_i;
        dfi_data_o <= wr_data_i;
      end else if (wr_ready_o) begin
        dfi_mask_o    <= {MW{1'b1}};
        dfi_data_o    <= '0;
        wr_underrun_o <= 1'b1;
      end else begin
        dfi_mask_o <= '0;
        dfi_data_o <= '0;
      end
    end
  end

  // Read path: read-enable window and registered PHY return with burst beat counting
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_hist    <= '0;
      dfi_rden_o <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_last_o  <= 1'b0;
      rd_data_o  <= '0;
      rd_beat    <= 2'd0;
    end else begin
      rd_hist    <= {rd_hist[RD_LAT+1:0], iss_read};
      dfi_rden_o <= rden_next;
      rd_valid_o <= dfi_valid_i;
      rd_data_o  <= dfi_data_i;
      rd_last_o  <= dfi_valid_i && (rd_beat == 2'd3);
      if (dfi_valid_i)
        rd_beat <= rd_beat + 2'd1;
    end
  end

endmodule

// File: tb/tb_ddr3_dfi_sequencer.sv
// tb/tb_ddr3_dfi_sequencer.sv - directed self-checking bench for ddr3_dfi_sequencer
module tb_ddr3_dfi_sequencer;

  localparam int DW  = 32;
  localparam int MW  = 4;
  localparam int AB  = 14;
  localparam int LOG = 1024;

  localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3,
                         PRE = 3'd4, REF = 3'd6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ctl_cke = 1'b0, ctl_rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [2:0]    cmd_code = 3'd0, cmd_bank = 3'd0;
  logic [AB-1:0] cmd_addr = '0;
  logic          wr_valid = 1'b0, wr_ready;
  logic [MW-1:0] wr_mask = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid, rd_last, wr_underrun;
  logic [DW-1:0] rd_data;
  logic          dfi_cke, dfi_rst_n, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt;
  logic [2:0]    dfi_bank;
  logic [AB-1:0] dfi_addr;
  logic          dfi_wren, dfi_rden;
  logic [MW-1:0] dfi_mask;
  logic [DW-1:0] dfi_data;
  logic          dfi_valid = 1'b0;
  logic [DW-1:0] dfi_rdata = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [DW-1:0] beats [4] = '{32'h0000000A, 32'h0000000B, 32'h0000000C, 32'h0000000D};

  logic          wren_l [LOG], rden_l [LOG], odt_l [LOG], a10_l [LOG], rv_l [LOG], rl_l [LOG];
  logic [3:0]    cmd_l  [LOG];
  logic [DW-1:0] wd_l   [LOG], rd_l [LOG];
  logic [MW-1:0] wm_l   [LOG];

  ddr3_dfi_sequencer dut (
    .clock(clock), .reset(reset),
    .ctl_cke_i(ctl_cke), .ctl_rst_ni(ctl_rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_code_i(cmd_code), .cmd_bank_i(cmd_bank), .cmd_addr_i(cmd_addr),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_mask_i(wr_mask), .wr_data_i(wr_data),
    .rd_valid_o(rd_valid), .rd_last_o(rd_last), .rd_data_o(rd_data),
    .wr_underrun_o(wr_underrun),
    .dfi_cke_o(dfi_cke), .dfi_rst_no(dfi_rst_n), .dfi_cs_no(dfi_cs_n),
    .dfi_ras_no(dfi_ras_n), .dfi_cas_no(dfi_cas_n), .dfi_we_no(dfi_we_n),
    .dfi_odt_o(dfi_odt), .dfi_bank_o(dfi_bank), .dfi_addr_o(dfi_addr),
    .dfi_wren_o(dfi_wren), .dfi_mask_o(dfi_mask), .dfi_data_o(dfi_data),
    .dfi_rden_o(dfi_rden), .dfi_valid_i(dfi_valid), .dfi_data_i(dfi_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // per-cycle record of DFI activity, sampled mid-cycle
  always @(negedge clock) begin
    if (cyc < LOG) begin
      wren_l[cyc] = dfi_wren;
      rden_l[cyc] = dfi_rden;
      odt_l[cyc]  = dfi_odt;
      a10_l[cyc]  = dfi_addr[10];
      cmd_l[cyc]  = {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n};
      wd_l[cyc]   = dfi_data;
      wm_l[cyc]   = dfi_mask;
      rv_l[cyc]   = rd_valid;
      rl_l[cyc]   = rd_last;
      rd_l[cyc]   = rd_data;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] code, input logic [AB-1:0] addr, output int acc);
    acc = -1;
    cmd_valid = 1'b1;
    cmd_code  = code;
    cmd_bank  = 3'd2;
    cmd_addr  = addr;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (cmd_ready) acc = cyc;
      @(posedge clock);
      #1;
      if (acc >= 0) break;
    end
    cmd_valid = 1'b0;
    cmd_code  = NOP;
    checks++;
    if (acc < 0) begin
      failures++;
      $display("FAIL send_accept code=%0d not accepted within 200 cycles", code);
    end
  endtask

  task automatic wr_feed(input int ncyc, input int skip);
    int k = 0;
    for (int n = 0; n < ncyc; n++) begin
      if (wr_ready && k < 4) begin
        wr_valid = (k != skip);
        wr_data  = beats[k];
        wr_mask  = 4'h3;
        k++;
      end else begin
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_mask  = '0;
      end
      step(1);
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] v;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(10);
    cmd_code = NOP;
    #1;
    v = {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_cke, dfi_rst_n, dfi_wren, dfi_rden, dfi_odt, wr_underrun};
    checks++;
    if (v !== 10'b1111000000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", v, 10'b1111000000);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_nop_ready got=%b exp=1", cmd_ready);
    end
    ctl_cke = 1'b1;
    ctl_rst_n = 1'b1;
    step(1);
    checks++;
    if ({dfi_cke, dfi_rst_n} !== 2'b11) begin
      failures++;
      $display("FAIL cke_rst_passthrough got=%b exp=11", {dfi_cke, dfi_rst_n});
    end
  endtask

  task automatic test_act_read();
    int a0, r;
    logic [5:0] v;
    send(ACT, 14'h0123, a0);
    send(RD, 14'h0400, r);
    step(12);
    checks++;
    if (r - a0 !== 6) begin
      failures++;
      $display("FAIL act_read_gap got=%0d exp=6", r - a0);
    end
    checks++;
    if (cmd_l[a0+1] !== 4'b0011) begin
      failures++;
      $display("FAIL act_encoding got=%b exp=0011", cmd_l[a0+1]);
    end
    checks++;
    if ({cmd_l[r+1], a10_l[r+1]} !== 5'b01010) begin
      failures++;
      $display("FAIL read_encoding got=%b exp=01010", {cmd_l[r+1], a10_l[r+1]});
    end
    v = '0;
    for (int k = 0; k < 6; k++) v = {v[4:0], rden_l[r+5+k]};
    checks++;
    if (v !== 6'b011110) begin
      failures++;
      $display("FAIL rden_window got=%b exp=011110", v);
    end
  endtask

  task automatic test_read_return();
    logic [8:0] pat = 9'b111110111;
    logic [8:0] vv, lv;
    int s;
    s = cyc;
    for (int i = 0; i < 9; i++) begin
      dfi_valid = pat[8-i];
      dfi_rdata = 32'h100 + i;
      step(1);
    end
    dfi_valid = 1'b0;
    step(2);
    vv = '0;
    lv = '0;
    for (int i = 0; i < 9; i++) begin
      vv = {vv[7:0], rv_l[s+1+i]};
      lv = {lv[7:0], rl_l[s+1+i]};
    end
    checks++;
    if (vv !== 9'b111110111) begin
      failures++;
      $display("FAIL rd_valid_pattern got=%b exp=111110111", vv);
    end
    checks++;
    if (lv !== 9'b000100001) begin
      failures++;
      $display("FAIL rd_last_pattern got=%b exp=000100001", lv);
    end
    checks++;
    if (rd_l[s+4] !== 32'h103) begin
      failures++;
      $display("FAIL rd_data_beat3 got=%h exp=%h", rd_l[s+4], 32'h103);
    end
  endtask

  task automatic test_write();
    int w, p;
    logic [5:0] v;
    logic [7:0] o;
    fork
      begin
        send(WR, 14'h0400, w);
        send(PRE, 14'h0400, p);
      end
      wr_feed(24, -1);
    join
    step(2);
    checks++;
    if ({cmd_l[w+1], a10_l[w+1]} !== 5'b01000) begin
      failures++;
      $display("FAIL write_encoding got=%b exp=01000", {cmd_l[w+1], a10_l[w+1]});
    end
    v = '0;
    for (int k = 0; k < 6; k++) v = {v[4:0], wren_l[w+4+k]};
    checks++;
    if (v !== 6'b011110) begin
      failures++;
      $display("FAIL wren_window got=%b exp=011110", v);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({wm_l[w+5+k], wd_l[w+5+k]} !== {4'h3, beats[k]}) begin
        failures++;
        $display("FAIL write_beat%0d got=%h exp=%h", k, {wm_l[w+5+k], wd_l[w+5+k]}, {4'h3, beats[k]});
      end
    end
    o = '0;
    for (int k = 0; k < 8; k++) o = {o[6:0], odt_l[w+3+k]};
    checks++;
    if (o !== 8'b01111110) begin
      failures++;
      $display("FAIL odt_window got=%b exp=01111110", o);
    end
    checks++;
    if (p - w !== 14) begin
      failures++;
      $display("FAIL pre_after_write_gap got=%0d exp=14", p - w);
    end
    checks++;
    if ({cmd_l[p+1], a10_l[p+1]} !== 5'b00100) begin
      failures++;
      $display("FAIL pre_encoding got=%b exp=00100", {cmd_l[p+1], a10_l[p+1]});
    end
    checks++;
    if (wr_underrun !== 1'b0) begin
      failures++;
      $display("FAIL underrun_clean got=%b exp=0", wr_underrun);
    end
  endtask

  task automatic test_underrun();
    int w;
    fork
      send(WR, 14'h0010, w);
      wr_feed(14, 2);
    join
    checks++;
    if ({wm_l[w+6], wd_l[w+6]} !== {4'h3, beats[1]}) begin
      failures++;
      $display("FAIL underrun_good_beat got=%h exp=%h", {wm_l[w+6], wd_l[w+6]}, {4'h3, beats[1]});
    end
    checks++;
    if ({wm_l[w+7], wd_l[w+7]} !== {4'hF, 32'h0}) begin
      failures++;
      $display("FAIL underrun_masked_beat got=%h exp=%h", {wm_l[w+7], wd_l[w+7]}, {4'hF, 32'h0});
    end
    checks++;
    if (wr_underrun !== 1'b1) begin
      failures++;
      $display("FAIL underrun_set got=%b exp=1", wr_underrun);
    end
    step(5);
    checks++;
    if (wr_underrun !== 1'b1) begin
      failures++;
      $display("FAIL underrun_sticky got=%b exp=1", wr_underrun);
    end
  endtask

  task automatic test_back_to_back();
    int r, w, w2, r2, r3;
    logic [9:0]  v;
    logic [11:0] o;
    send(RD, '0, r);
    send(WR, '0, w);
    send(WR, '0, w2);
    send(RD, '0, r2);
    send(RD, '0, r3);
    step(14);
    checks++;
    if (w - r !== 6) begin
      failures++;
      $display("FAIL read_to_write_gap got=%0d exp=6", w - r);
    end
    checks++;
    if (w2 - w !== 4) begin
      failures++;
      $display("FAIL write_to_write_gap got=%0d exp=4", w2 - w);
    end
    checks++;
    if (r2 - w2 !== 12) begin
      failures++;
      $display("FAIL write_to_read_gap got=%0d exp=12", r2 - w2);
    end
    checks++;
    if (r3 - r2 !== 4) begin
      failures++;
      $display("FAIL read_to_read_gap got=%0d exp=4", r3 - r2);
    end
    v = '0;
    for (int k = 0; k < 10; k++) v = {v[8:0], wren_l[w+4+k]};
    checks++;
    if (v !== 10'b0111111110) begin
      failures++;
      $display("FAIL wren_continuous got=%b exp=0111111110", v);
    end
    o = '0;
    for (int k = 0; k < 12; k++) o = {o[10:0], odt_l[w+3+k]};
    checks++;
    if (o !== 12'b011111111110) begin
      failures++;
      $display("FAIL odt_merged got=%b exp=011111111110", o);
    end
    v = '0;
    for (int k = 0; k < 10; k++) v = {v[8:0], rden_l[r2+5+k]};
    checks++;
    if (v !== 10'b0111111110) begin
      failures++;
      $display("FAIL rden_continuous got=%b exp=0111111110", v);
    end
  endtask

  task automatic test_ref_reset();
    int r, f, rel, a;
    logic [9:0] v;
    send(RD, '0, r);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(10);
    v = '0;
    for (int k = 0; k < 10; k++) v = {v[8:0], rden_l[r+3+k]};
    checks++;
    if (v !== 10'b0) begin
      failures++;
      $display("FAIL burst_abandoned_on_reset got=%b exp=0000000000", v);
    end
    send(REF, '0, f);
    step(4);
    cmd_code = ACT;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL act_blocked_in_trfc got=%b exp=0", cmd_ready);
    end
    cmd_code = NOP;
    step(5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    rel = cyc;
    checks++;
    if ({dfi_cke, dfi_cs_n, dfi_wren, dfi_rden, dfi_odt} !== 5'b01000) begin
      failures++;
      $display("FAIL post_reset_outputs got=%b exp=01000", {dfi_cke, dfi_cs_n, dfi_wren, dfi_rden, dfi_odt});
    end
    send(ACT, '0, a);
    checks++;
    if (cmd_l[f+1] !== 4'b0001) begin
      failures++;
      $display("FAIL ref_encoding got=%b exp=0001", cmd_l[f+1]);
    end
    checks++;
    if (a !== rel) begin
      failures++;
      $display("FAIL act_after_reset got=%0d exp=%0d", a, rel);
    end
  endtask

  initial begin
    test_reset();
    test_act_read();
    test_read_return();
    test_write();
    test_underrun();
    test_back_to_back();
    test_ref_reset();
    step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
